// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and the round-robin priority search used by
// mux_nway_arb and rr_arbiter.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_CH = 4;
  localparam int MAX_CH     = 16;

  // Rotate-and-find-first: one-hot grant for the first set bit of req,
  // searching upward from ptr and wrapping at n-1 back to 0.
  function automatic logic [MAX_CH-1:0] rr_first_onehot(
    input logic [MAX_CH-1:0] req,
    input logic [3:0]        ptr,
    input int                n
  );
    logic [MAX_CH-1:0] gnt;
    logic              found;
    logic [4:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 5'(k);
        if (idx >= 5'(n)) idx = idx - 5'(n);
        if (!found && req[idx[3:0]]) begin
          gnt[idx[3:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_CH requesters. Holds the rotating
// priority pointer; a lock input pins the grant to one requester.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_advance,
  input  logic [SEL_W-1:0]  i_adv_idx,
  input  logic              i_lock,
  input  logic [SEL_W-1:0]  i_lock_idx,
  output logic [NUM_CH-1:0] o_grant,
  output logic [SEL_W-1:0]  o_idx
);

  logic [SEL_W-1:0]  r_ptr;
  logic [NUM_CH-1:0] w_search;

  // Pick the grant: locked requester if a lock is held, else rotating search.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned, which would infer a latch.
    o_grant  = '0;
    o_idx    = '0;
    w_search = NUM_CH'(rr_first_onehot(MAX_CH'(i_req), 4'(r_ptr), NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_lock) o_grant[i] = (i_lock_idx == SEL_W'(i)) && i_req[i];
      else        o_grant[i] = w_search[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (o_grant[i]) o_idx = SEL_W'(i);
    end
  end

  // Pointer moves to the channel after the one that just completed.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (i_adv_idx == SEL_W'(NUM_CH - 1)) ? '0 : i_adv_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: NUM_CH valid/ready channels into one registered output,
// fixed-select or round-robin. Optional packet locking is enabled by
// defining MUX_PKT_LOCK_EN (adds in_last / out_last).
module mux_nway_arb
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_ch;

  logic              w_load_ok;
  logic              w_xfer;
  logic              w_advance;
  logic              w_mode_eff;
  logic              w_lock;
  logic              w_last_beat;
  logic [SEL_W-1:0]  w_lock_idx;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [NUM_CH-1:0] w_fix_grant;
  logic [NUM_CH-1:0] w_rr_grant;
  logic [NUM_CH-1:0] w_grant;
  logic [WIDTH-1:0]  w_mux_data;

  assign w_load_ok = !r_out_valid || out_ready;

  // Fixed select: an out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    w_fix_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_fix_grant[i] = (sel == SEL_W'(i)) && in_valid[i];
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (in_valid),
    .i_advance  (w_advance),
    .i_adv_idx  (w_grant_idx),
    .i_lock     (w_lock),
    .i_lock_idx (w_lock_idx),
    .o_grant    (w_rr_grant),
    .o_idx      (w_rr_idx)
  );

  // A held lock routes through the arbiter regardless of mode.
  assign w_grant     = (w_lock || mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_grant_idx = (w_lock || mode == MODE_RR) ? w_rr_idx   : sel;

  assign in_ready  = w_grant & {NUM_CH{w_load_ok && rst_n}};
  assign w_xfer    = |in_ready;
  assign w_advance = w_xfer && w_last_beat && (w_mode_eff == MODE_RR);

  // AND-OR data mux over the one-hot grant.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  // One-entry output stage: load on transfer, drain to empty otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load_ok) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_mux_data;
        r_out_ch   <= w_grant_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

`ifdef MUX_PKT_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;
  logic             r_lock_mode;
  logic             r_out_last;

  assign w_lock      = r_lock;
  assign w_lock_idx  = r_lock_idx;
  assign w_mode_eff  = r_lock ? r_lock_mode : mode;
  assign w_last_beat = |(in_last & w_grant);

  // Lock onto a channel at a non-last beat; release on its last beat.
  // The mode seen at packet start governs the pointer at packet end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
      r_lock_mode <= MODE_FIXED;
    end else if (w_xfer) begin
      if (w_last_beat) begin
        r_lock <= 1'b0;
      end else begin
        r_lock      <= 1'b1;
        r_lock_idx  <= w_grant_idx;
        r_lock_mode <= w_mode_eff;
      end
    end
  end

  // out_last travels with out_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_last <= 1'b0;
    end else if (w_load_ok && w_xfer) begin
      r_out_last <= w_last_beat;
    end
  end

  assign out_last = r_out_last;
`else
  assign w_lock      = 1'b0;
  assign w_lock_idx  = '0;
  assign w_mode_eff  = mode;
  assign w_last_beat = 1'b1;
`endif

endmodule

// File: tb/tb_mux_nway_arb.sv
// tb_mux_nway_arb: directed-vector bench for mux_nway_arb. A second
// instance with NUM_CH=6 exercises out-of-range select values.
module tb_mux_nway_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic [95:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [15:0] out_data6;
  logic        out_valid6;
  logic [2:0]  out_ch6;
  logic        out_ready6;

`ifdef MUX_PKT_LOCK_EN
  logic [3:0] in_last;
  logic       out_last;
  logic [5:0] in_last6;
  logic       out_last6;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_nway_arb #(.WIDTH(16), .NUM_CH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  mux_nway_arb #(.WIDTH(16), .NUM_CH(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data6),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .mode      (mode6),
    .sel       (sel6),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last6),
    .out_last  (out_last6),
`endif
    .out_data  (out_data6),
    .out_valid (out_valid6),
    .out_ch    (out_ch6),
    .out_ready (out_ready6)
  );

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic to_post;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      to_post();
      to_neg();
      n_checks++;
      if (in_ready !== 4'b0000 || in_ready6 !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_ready cycle %0d: got %b/%b expected 0000/000000", c, in_ready, in_ready6);
      end
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b0, 16'h0000, 2'd0} || out_valid6 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out cycle %0d: got v=%b d=%h ch=%0d v6=%b expected v=0 d=0000 ch=0 v6=0",
                 c, out_valid, out_data, out_ch, out_valid6);
      end
    end
    in_valid  = 4'b0000;
    in_valid6 = 6'b000000;
    to_post();
    rst_n = 1'b1;
  endtask

  task automatic test_fixed;
    mode      = 1'b0;
    sel       = 2'd2;
    in_data   = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
    in_valid  = 4'b0101;
    out_ready = 1'b1;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_ready: got %b expected 0100", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 16'hBEEF, 2'd2}) begin
      n_fail++;
      $display("FAIL fixed_out: got v=%b d=%h ch=%0d expected v=1 d=beef ch=2", out_valid, out_data, out_ch);
    end
    in_valid = 4'b0001;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL fixed_ch0_blocked: got %b expected 0000", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b0, 16'hBEEF, 2'd2}) begin
      n_fail++;
      $display("FAIL fixed_drain_hold: got v=%b d=%h ch=%0d expected v=0 d=beef ch=2", out_valid, out_data, out_ch);
    end
    in_valid = 4'b0000;

    // Out-of-range select on the six-channel instance.
    mode6      = 1'b0;
    out_ready6 = 1'b1;
    in_data6   = {16'h0605, 16'h0604, 16'h0603, 16'h0602, 16'h0601, 16'h0600};
    in_valid6  = 6'b111111;
    for (int s = 6; s < 8; s++) begin
      sel6 = 3'(s);
      to_neg();
      n_checks++;
      if (in_ready6 !== 6'b000000) begin
        n_fail++;
        $display("FAIL fixed_sel_range sel=%0d: got %b expected 000000", s, in_ready6);
      end
      to_post();
      n_checks++;
      if (out_valid6 !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_sel_range_out sel=%0d: got v=%b expected v=0", s, out_valid6);
      end
    end
    sel6 = 3'd5;
    to_neg();
    n_checks++;
    if (in_ready6 !== 6'b100000) begin
      n_fail++;
      $display("FAIL fixed_sel_top_ready: got %b expected 100000", in_ready6);
    end
    to_post();
    n_checks++;
    if ({out_valid6, out_data6, out_ch6} !== {1'b1, 16'h0605, 3'd5}) begin
      n_fail++;
      $display("FAIL fixed_sel_top_out: got v=%b d=%h ch=%0d expected v=1 d=0605 ch=5", out_valid6, out_data6, out_ch6);
    end
    in_valid6 = 6'b000000;
    sel6      = 3'd7;
  endtask

  task automatic test_rr_fairness;
    logic [3:0] exp_oh [4];
    exp_oh    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mode      = 1'b1;
    in_data   = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      to_neg();
      n_checks++;
      if (in_ready !== exp_oh[k % 4]) begin
        n_fail++;
        $display("FAIL rr_ready beat %0d: got %b expected %b", k, in_ready, exp_oh[k % 4]);
      end
      to_post();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, 16'(k % 4), 2'(k % 4)}) begin
        n_fail++;
        $display("FAIL rr_out beat %0d: got v=%b d=%h ch=%0d expected v=1 ch=%0d", k, out_valid, out_data, out_ch, k % 4);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      to_neg();
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready cycle %0d: got %b expected 0000", c, in_ready);
      end
      to_post();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, 16'h0003, 2'd3}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got v=%b d=%h ch=%0d expected v=1 d=0003 ch=3", c, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b expected 0001", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 16'h0000, 2'd0}) begin
      n_fail++;
      $display("FAIL stall_release_out: got v=%b d=%h ch=%0d expected v=1 d=0000 ch=0", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_sparse;
    // Pointer is at 1 here; one more full-request beat moves it to 2.
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sparse_setup: got %b expected 0010", in_ready);
    end
    to_post();
    in_valid = 4'b1010;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL sparse_first_ready: got %b expected 1000", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 16'h0003, 2'd3}) begin
      n_fail++;
      $display("FAIL sparse_first_out: got v=%b d=%h ch=%0d expected v=1 d=0003 ch=3", out_valid, out_data, out_ch);
    end
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sparse_second_ready: got %b expected 0010", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 16'h0001, 2'd1}) begin
      n_fail++;
      $display("FAIL sparse_second_out: got v=%b d=%h ch=%0d expected v=1 d=0001 ch=1", out_valid, out_data, out_ch);
    end
    in_valid = 4'b1111;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sparse_ptr_end: got %b expected 0100", in_ready);
    end
    to_post();
  endtask

  task automatic test_reset_midstream;
    rst_n = 1'b0;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b expected 0000", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b0, 16'h0000, 2'd0}) begin
      n_fail++;
      $display("FAIL midrst_out: got v=%b d=%h ch=%0d expected v=0 d=0000 ch=0", out_valid, out_data, out_ch);
    end
    rst_n = 1'b1;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_ptr: got %b expected 0001", in_ready);
    end
    #1;
    in_valid = 4'b0000;
    to_post();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got v=%b expected v=0", out_valid);
    end
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_pkt_lock;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    in_last   = 4'b0000;
    in_data   = {16'h0000, 16'h0000, 16'hB001, 16'hA001};
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_beat1_ready: got %b expected 0001", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch, out_last} !== {1'b1, 16'hA001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_beat1_out: got v=%b d=%h ch=%0d l=%b expected v=1 d=a001 ch=0 l=0", out_valid, out_data, out_ch, out_last);
    end
    mode    = 1'b0;
    sel     = 2'd1;
    in_data = {16'h0000, 16'h0000, 16'hB001, 16'hA002};
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_beat2_ready: got %b expected 0001", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch, out_last} !== {1'b1, 16'hA002, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_beat2_out: got v=%b d=%h ch=%0d l=%b expected v=1 d=a002 ch=0 l=0", out_valid, out_data, out_ch, out_last);
    end
    in_data = {16'h0000, 16'h0000, 16'hB001, 16'hA003};
    in_last = 4'b0001;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_beat3_ready: got %b expected 0001", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch, out_last} !== {1'b1, 16'hA003, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_beat3_out: got v=%b d=%h ch=%0d l=%b expected v=1 d=a003 ch=0 l=1", out_valid, out_data, out_ch, out_last);
    end
    in_last = 4'b0010;
    to_neg();
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_release_ready: got %b expected 0010", in_ready);
    end
    to_post();
    n_checks++;
    if ({out_valid, out_data, out_ch, out_last} !== {1'b1, 16'hB001, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_release_out: got v=%b d=%h ch=%0d l=%b expected v=1 d=b001 ch=1 l=1", out_valid, out_data, out_ch, out_last);
    end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 4'b1111;
    mode       = 1'b1;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_data6   = '0;
    in_valid6  = 6'b111111;
    mode6      = 1'b1;
    sel6       = 3'd0;
    out_ready6 = 1'b1;
`ifdef MUX_PKT_LOCK_EN
    in_last    = 4'b0000;
    in_last6   = 6'b000000;
`endif
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_backpressure();
    test_sparse();
    test_reset_midstream();
`ifdef MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
